audio_stream_scheduler: RTL and testbench
=========================================

Name: audio_stream_scheduler

Overview:
Sequences the sample handshakes between the codec FIFO interface (audio_in_available/read_audio_in, audio_out_allowed/write_audio_out) and the rest of the audio design. It is paced by the ADC sample stream. Each captured input sample defines one output slot, which is filled according to the selected mode: mute, passthrough, tone, or saturating mix of mic and tone. It also shares the output slot with a tone-generator requester through a valid/ready handshake, reports underruns and dropped samples, and emits a frame tick for block-energy logic.

Parameters:
FRAME_LEN, 480, samples per frame; frame_tick period.
OUT_TIMEOUT, 4096, CLOCK_50 cycles to wait for audio_out_allowed before dropping a slot.
CNT_W, 16, width of the saturating status counters.

Ports:
CLOCK_50  in  1  system clock; all logic is on its rising edge.
reset_n  in  1  synchronous, active-low reset.
mode  in  2  0=MUTE, 1=PASS, 2=TONE, 3=MIX.
audio_in_available  in  1  codec input FIFO non-empty; data is valid in the same cycle (show-ahead).
left_channel_audio_in  in  32  signed left input sample.
right_channel_audio_in  in  32  signed right input sample.
read_audio_in  out  1  one-cycle pop of the input FIFO.
audio_out_allowed  in  1  codec output FIFO has space.
write_audio_out  out  1  one-cycle push to the output FIFO.
left_channel_audio_out  out  32  registered left output sample.
right_channel_audio_out  out  32  registered right output sample.
tone_valid  in  1  tone requester has a sample.
tone_left  in  32  signed left tone sample.
tone_right  in  32  signed right tone sample.
tone_ready  out  1  one-cycle acceptance of the tone sample.
frame_tick  out  1  one-cycle pulse on the write that completes a frame.
underrun_cnt  out  CNT_W  count of tone slots where tone_valid was low.
drop_cnt  out  CNT_W  count of slots dropped on OUT_TIMEOUT.
busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - All outputs, sample registers and counters go to 0.
  - No pulse may appear in the cycle after reset is released.
  - Reset mid-slot discards the held sample without writing it.
- FSM states: IDLE, MIX, WAIT_OUT.
- IDLE:
  - If audio_in_available=1, assert read_audio_in for this cycle only and register both input samples.
  - In the same cycle, latch mode into mode_q. A mode change takes effect on the next captured sample, never mid-slot.
  - If mode uses tone (TONE or MIX) and tone_valid=1, assert tone_ready this cycle and register the tone samples.
  - If mode uses tone and tone_valid=0, the tone term is 0 and underrun_cnt increments.
  - Next state is MIX.
- MIX (one cycle): compute the output registers from mode_q.
  - MUTE: output 0.
  - PASS: output the input sample.
  - TONE: output the tone sample.
  - MIX: 33-bit signed sum of input and tone, clamped to 32'h7FFFFFFF / 32'h80000000.
  - Next state is WAIT_OUT; the timeout counter clears.
- WAIT_OUT:
  - If audio_out_allowed=1, assert write_audio_out for one cycle, increment the sample counter, and return to IDLE.
  - Otherwise increment the timeout counter. On reaching OUT_TIMEOUT-1, drop the slot (no write), increment drop_cnt, and return to IDLE.
- Latency: capture to write is at least 2 cycles (IDLE→MIX→WAIT_OUT write). A new capture is possible in the cycle after the write, so the minimum slot is 3 cycles.
- Mutual exclusion:
  - read_audio_in and write_audio_out are never high in the same cycle.
  - tone_ready only ever pulses coincident with read_audio_in.
- Output data is held stable from MIX until the next MIX.
- Sample counter:
  - Wraps from FRAME_LEN-1 to 0 on a write.
  - frame_tick is asserted in the same cycle as the write that wraps it.
  - Dropped slots do not advance the counter.
- Status counters (underrun_cnt, drop_cnt) saturate at all-ones; they never wrap.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - mode enum: MODE_MUTE, MODE_PASS, MODE_TONE, MODE_MIX.
  - state enum: ST_IDLE, ST_MIX, ST_WAIT_OUT.
  - constant SAT_POS=32'h7FFFFFFF.
  - constant SAT_NEG=32'h80000000.
- One natural sub-module: sat_add32, the combinational 32-bit signed saturating adder, instantiated once per channel.
- Status counters are inline.

Test Plan:
- Reset while in WAIT_OUT with audio_out_allowed=0 → next cycle state=IDLE, all outputs 0, no write_audio_out pulse ever for the held sample.
- mode=PASS, in=32'h00001234/32'hFFFF0000, audio_out_allowed=1 → read pulse at cycle t, write pulse at t+2 with identical data, tone_ready never high.
- mode=MIX, in=32'h7FFFFF00, tone=32'h00001000, tone_valid=1 → left out=32'h7FFFFFFF; with in=32'h80000010 and tone=32'hFFFFFF00 → 32'h80000000.
- mode=TONE, tone_valid=0 for 3 consecutive slots → outputs 0, underrun_cnt=3, writes still issued.
- audio_out_allowed held 0 for OUT_TIMEOUT cycles after MIX → no write, drop_cnt=1, return to IDLE, next available sample captured normally.
- FRAME_LEN=4, continuous PASS traffic for 9 writes → frame_tick on writes 4 and 8 only; mode changed mid-slot applies only from the next capture.

Source files
------------

// File: rtl/audio_stream_scheduler_pkg.sv
// Shared types and constants for the audio stream scheduler.
package audio_stream_scheduler_pkg;

    typedef enum logic [1:0] {
        MODE_MUTE = 2'd0,
        MODE_PASS = 2'd1,
        MODE_TONE = 2'd2,
        MODE_MIX  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MIX      = 2'd1,
        ST_WAIT_OUT = 2'd2
    } state_e;

    localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
    localparam logic [31:0] SAT_NEG = 32'h80000000;

    // Modes whose output slot consumes a tone sample.
    function automatic logic mode_uses_tone(input mode_e m);
        return (m == MODE_TONE) || (m == MODE_MIX);
    endfunction

endpackage

// File: rtl/audio_stream_scheduler_sat_add32.sv
// Combinational 32-bit signed adder clamped to the signed 32-bit range.
module sat_add32
    import audio_stream_scheduler_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    logic [32:0] w_wide;

    assign w_wide = {i_a[31], i_a} + {i_b[31], i_b};

    // Overflow shows as disagreement between the two top bits of the wide sum.
    always_comb begin
        if (w_wide[32] != w_wide[31]) begin
            o_sum = w_wide[32] ? SAT_NEG : SAT_POS;
        end else begin
            o_sum = w_wide[31:0];
        end
    end

endmodule

// File: rtl/audio_stream_scheduler.sv
// Paces codec FIFO handshakes: one captured ADC sample defines one output slot.
module audio_stream_scheduler
    import audio_stream_scheduler_pkg::*;
#(
    parameter int FRAME_LEN   = 480,
    parameter int OUT_TIMEOUT = 4096,
    parameter int CNT_W       = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    input  logic              tone_valid,
    input  logic [31:0]       tone_left,
    input  logic [31:0]       tone_right,
    output logic              tone_ready,
    output logic              frame_tick,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam int SC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TO_W = (OUT_TIMEOUT > 1) ? $clog2(OUT_TIMEOUT) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(FRAME_LEN - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(OUT_TIMEOUT - 1);

    state_e            r_state;
    mode_e             r_mode_q;
    logic              r_live;
    logic [31:0]       r_in_l, r_in_r, r_tone_l, r_tone_r;
    logic [31:0]       r_out_l, r_out_r;
    logic [TO_W-1:0]   r_timeout;
    logic [SC_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]  r_underrun, r_drop;

    logic              w_uses_tone, w_capture, w_tone_take, w_underrun;
    logic              w_write, w_drop;
    logic [31:0]       w_mix_l, w_mix_r;

    // Pulses are gated by reset_n and r_live so nothing fires during reset or
    // in the first cycle after it is released.
    assign w_uses_tone = mode_uses_tone(mode_e'(mode));
    assign w_capture   = reset_n && r_live && (r_state == ST_IDLE) && audio_in_available;
    assign w_tone_take = w_capture && w_uses_tone && tone_valid;
    assign w_underrun  = w_capture && w_uses_tone && !tone_valid;
    assign w_write     = reset_n && (r_state == ST_WAIT_OUT) && audio_out_allowed;
    assign w_drop      = reset_n && (r_state == ST_WAIT_OUT) && !audio_out_allowed
                         && (r_timeout == TO_LAST);

    assign read_audio_in           = w_capture;
    assign tone_ready              = w_tone_take;
    assign write_audio_out         = w_write;
    assign frame_tick              = w_write && (r_sample_cnt == SC_LAST);
    assign busy                    = (r_state != ST_IDLE);
    assign left_channel_audio_out  = r_out_l;
    assign right_channel_audio_out = r_out_r;
    assign underrun_cnt            = r_underrun;
    assign drop_cnt                = r_drop;

    sat_add32 u_sat_l (.i_a(r_in_l), .i_b(r_tone_l), .o_sum(w_mix_l));
    sat_add32 u_sat_r (.i_a(r_in_r), .i_b(r_tone_r), .o_sum(w_mix_r));

    // Arms the handshake outputs one cycle after reset is released.
    always_ff @(posedge CLOCK_50) begin
        r_live <= reset_n;
    end

    // Slot sequencing and output-wait timeout.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_timeout <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) r_state <= ST_MIX;
                end
                ST_MIX: begin
                    r_state   <= ST_WAIT_OUT;
                    r_timeout <= '0;
                end
                ST_WAIT_OUT: begin
                    if (w_write || w_drop) r_state <= ST_IDLE;
                    else                   r_timeout <= r_timeout + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Capture of input samples, tone samples and the slot mode.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_mode_q <= MODE_MUTE;
            r_in_l   <= '0;
            r_in_r   <= '0;
            r_tone_l <= '0;
            r_tone_r <= '0;
        end else if (w_capture) begin
            r_mode_q <= mode_e'(mode);
            r_in_l   <= left_channel_audio_in;
            r_in_r   <= right_channel_audio_in;
            r_tone_l <= w_tone_take ? tone_left  : '0;
            r_tone_r <= w_tone_take ? tone_right : '0;
        end
    end

    // Output samples are formed once per slot and held until the next slot.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_out_l <= '0;
            r_out_r <= '0;
        end else if (r_state == ST_MIX) begin
            case (r_mode_q)
                MODE_PASS: begin r_out_l <= r_in_l;   r_out_r <= r_in_r;   end
                MODE_TONE: begin r_out_l <= r_tone_l; r_out_r <= r_tone_r; end
                MODE_MIX:  begin r_out_l <= w_mix_l;  r_out_r <= w_mix_r;  end
                default:   begin r_out_l <= '0;       r_out_r <= '0;       end
            endcase
        end
    end

    // Frame position advances only on real writes.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_sample_cnt <= '0;
        end else if (w_write) begin
            r_sample_cnt <= (r_sample_cnt == SC_LAST) ? '0 : r_sample_cnt + 1'b1;
        end
    end

    // Saturating status counters.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_underrun <= '0;
            r_drop     <= '0;
        end else begin
            if (w_underrun && (r_underrun != '1)) r_underrun <= r_underrun + 1'b1;
            if (w_drop && (r_drop != '1))         r_drop     <= r_drop + 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_stream_scheduler.sv
// Self-checking bench for audio_stream_scheduler with a slot-level reference model.
module tb_audio_stream_scheduler;

    localparam int FRAME_LEN   = 4;
    localparam int OUT_TIMEOUT = 16;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic              CLOCK_50;
    logic              reset_n;
    logic [1:0]        mode;
    logic              audio_in_available;
    logic [31:0]       left_channel_audio_in;
    logic [31:0]       right_channel_audio_in;
    logic              read_audio_in;
    logic              audio_out_allowed;
    logic              write_audio_out;
    logic [31:0]       left_channel_audio_out;
    logic [31:0]       right_channel_audio_out;
    logic              tone_valid;
    logic [31:0]       tone_left;
    logic [31:0]       tone_right;
    logic              tone_ready;
    logic              frame_tick;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          exp_under;
    int          exp_drop;
    int          exp_pos;
    int          tick_count;
    logic [31:0] prev_l, prev_r;

    audio_stream_scheduler #(
        .FRAME_LEN   (FRAME_LEN),
        .OUT_TIMEOUT (OUT_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset_n                 (reset_n),
        .mode                    (mode),
        .audio_in_available      (audio_in_available),
        .left_channel_audio_in   (left_channel_audio_in),
        .right_channel_audio_in  (right_channel_audio_in),
        .read_audio_in           (read_audio_in),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .tone_valid              (tone_valid),
        .tone_left               (tone_left),
        .tone_right              (tone_right),
        .tone_ready              (tone_ready),
        .frame_tick              (frame_tick),
        .underrun_cnt            (underrun_cnt),
        .drop_cnt                (drop_cnt),
        .busy                    (busy)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output of one slot from the mode rules, using wide arithmetic.
    function automatic logic [31:0] ref_out(input int m, input logic [31:0] in_s,
                                           input logic [31:0] tone_s, input bit tone_ok);
        longint      s;
        logic [31:0] t;
        t = tone_ok ? tone_s : 32'd0;
        case (m)
            0: return 32'd0;
            1: return in_s;
            2: return t;
            default: begin
                s = longint'($signed(in_s)) + longint'($signed(t));
                if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
                if (s < -64'sd2147483648) return 32'h80000000;
                return s[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) r = {{16{r[15]}}, r[15:0]};
        return r;
    endfunction

    // One complete slot starting in IDLE at posedge+1; ends at posedge+1 back in IDLE.
    // stall = WAIT_OUT cycles with audio_out_allowed low before it goes high.
    task automatic run_slot(input int m, input logic [31:0] il, input logic [31:0] ir,
                            input bit tv, input logic [31:0] tl, input logic [31:0] tr,
                            input int stall);
        logic [31:0] el, er;
        bit          use_t, allowed, done;
        use_t = (m == 2) || (m == 3);
        el = ref_out(m, il, tl, use_t && tv);
        er = ref_out(m, ir, tr, use_t && tv);

        mode = m[1:0];
        audio_in_available = 1'b1;
        left_channel_audio_in = il;
        right_channel_audio_in = ir;
        tone_valid = tv;
        tone_left = tl;
        tone_right = tr;
        audio_out_allowed = 1'b0;
        #1;
        n_checks++;
        if (read_audio_in !== 1'b1) begin
            n_fail++; $display("FAIL capture_read: got %b expected 1", read_audio_in);
        end
        n_checks++;
        if (tone_ready !== (use_t && tv)) begin
            n_fail++; $display("FAIL capture_tone_ready: got %b expected %b", tone_ready, use_t && tv);
        end
        n_checks++;
        if (write_audio_out !== 1'b0) begin
            n_fail++; $display("FAIL capture_no_write: got %b expected 0", write_audio_out);
        end
        n_checks++;
        if (left_channel_audio_out !== prev_l || right_channel_audio_out !== prev_r) begin
            n_fail++; $display("FAIL hold_out: got %h/%h expected %h/%h",
                               left_channel_audio_out, right_channel_audio_out, prev_l, prev_r);
        end
        if (use_t && !tv && exp_under < CNT_MAX) exp_under++;

        // MIX cycle: scramble every input; none of it may affect this slot.
        @(posedge CLOCK_50); #1;
        mode = 2'($urandom_range(0, 3));
        left_channel_audio_in = $urandom;
        right_channel_audio_in = $urandom;
        tone_valid = 1'b1;
        tone_left = $urandom;
        tone_right = $urandom;
        audio_out_allowed = 1'b1;
        #1;
        n_checks++;
        if (read_audio_in !== 1'b0 || write_audio_out !== 1'b0 || tone_ready !== 1'b0) begin
            n_fail++; $display("FAIL mix_quiet: got rd=%b wr=%b tr=%b expected 0 0 0",
                               read_audio_in, write_audio_out, tone_ready);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL mix_busy: got %b expected 1", busy);
        end

        @(posedge CLOCK_50); #1;
        n_checks++;
        if (left_channel_audio_out !== el || right_channel_audio_out !== er) begin
            n_fail++; $display("FAIL slot_data m=%0d: got %h/%h expected %h/%h",
                               m, left_channel_audio_out, right_channel_audio_out, el, er);
        end

        for (int k = 0; k < OUT_TIMEOUT; k++) begin
            allowed = (k >= stall);
            audio_out_allowed = allowed;
            #1;
            n_checks++;
            if (read_audio_in !== 1'b0 || tone_ready !== 1'b0) begin
                n_fail++; $display("FAIL wait_no_read: got rd=%b tr=%b expected 0 0",
                                   read_audio_in, tone_ready);
            end
            n_checks++;
            if (write_audio_out !== allowed) begin
                n_fail++; $display("FAIL wait_write k=%0d: got %b expected %b", k, write_audio_out, allowed);
            end
            n_checks++;
            if (frame_tick !== (allowed && exp_pos == FRAME_LEN - 1)) begin
                n_fail++; $display("FAIL frame_tick pos=%0d: got %b expected %b",
                                   exp_pos, frame_tick, allowed && exp_pos == FRAME_LEN - 1);
            end
            if (allowed && frame_tick === 1'b1) tick_count++;
            if (allowed) exp_pos = (exp_pos + 1) % FRAME_LEN;
            else if (k == OUT_TIMEOUT - 1 && exp_drop < CNT_MAX) exp_drop++;
            done = allowed || (k == OUT_TIMEOUT - 1);
            @(posedge CLOCK_50); #1;
            if (done) break;
        end

        audio_out_allowed = 1'b0;
        audio_in_available = 1'b0;
        tone_valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL slot_end_idle: got busy=%b expected 0", busy);
        end
        n_checks++;
        if (underrun_cnt !== CNT_W'(exp_under) || drop_cnt !== CNT_W'(exp_drop)) begin
            n_fail++; $display("FAIL status_cnt: got und=%0d drop=%0d expected und=%0d drop=%0d",
                               underrun_cnt, drop_cnt, exp_under, exp_drop);
        end
        prev_l = el;
        prev_r = er;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mode = 2'd3;
        audio_in_available = 1'b1;
        audio_out_allowed = 1'b1;
        tone_valid = 1'b1;
        left_channel_audio_in = 32'h1111_1111;
        right_channel_audio_in = 32'h2222_2222;
        tone_left = 32'h3333_3333;
        tone_right = 32'h4444_4444;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        n_checks++;
        if (read_audio_in !== 1'b0 || write_audio_out !== 1'b0 || tone_ready !== 1'b0 ||
            frame_tick !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got rd=%b wr=%b tr=%b ft=%b busy=%b expected all 0",
                               read_audio_in, write_audio_out, tone_ready, frame_tick, busy);
        end
        n_checks++;
        if (left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0 ||
            underrun_cnt !== '0 || drop_cnt !== '0) begin
            n_fail++; $display("FAIL reset_values: got %h/%h und=%0d drop=%0d expected zeros",
                               left_channel_audio_out, right_channel_audio_out, underrun_cnt, drop_cnt);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (read_audio_in !== 1'b0 || tone_ready !== 1'b0 || write_audio_out !== 1'b0) begin
            n_fail++; $display("FAIL release_no_pulse: got rd=%b tr=%b wr=%b expected 0 0 0",
                               read_audio_in, tone_ready, write_audio_out);
        end
        audio_in_available = 1'b0;
        audio_out_allowed = 1'b0;
        tone_valid = 1'b0;
        @(posedge CLOCK_50); #1;
        exp_under = 0;
        exp_drop = 0;
        exp_pos = 0;
        tick_count = 0;
        prev_l = '0;
        prev_r = '0;
    endtask

    task automatic test_reset_mid_slot();
        mode = 2'd1;
        audio_in_available = 1'b1;
        left_channel_audio_in = 32'h5555_AAAA;
        right_channel_audio_in = 32'h0F0F_0F0F;
        audio_out_allowed = 1'b0;
        @(posedge CLOCK_50); #1;
        audio_in_available = 1'b0;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        @(posedge CLOCK_50); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midslot_busy: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        audio_out_allowed = 1'b1;
        #1;
        n_checks++;
        if (write_audio_out !== 1'b0) begin
            n_fail++; $display("FAIL midslot_reset_write: got %b expected 0", write_audio_out);
        end
        @(posedge CLOCK_50); #1;
        n_checks++;
        if (busy !== 1'b0 || left_channel_audio_out !== 32'd0 || right_channel_audio_out !== 32'd0) begin
            n_fail++; $display("FAIL midslot_reset_state: got busy=%b out=%h/%h expected 0 0/0",
                               busy, left_channel_audio_out, right_channel_audio_out);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (write_audio_out !== 1'b0) begin
                n_fail++; $display("FAIL midslot_held_written cyc=%0d: got %b expected 0", i, write_audio_out);
            end
            @(posedge CLOCK_50); #1;
        end
        audio_out_allowed = 1'b0;
        exp_under = 0;
        exp_drop = 0;
        exp_pos = 0;
        tick_count = 0;
        prev_l = '0;
        prev_r = '0;
    endtask

    task automatic test_pass();
        run_slot(1, 32'h00001234, 32'hFFFF0000, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0);
        n_checks++;
        if (left_channel_audio_out !== 32'h00001234 || right_channel_audio_out !== 32'hFFFF0000) begin
            n_fail++; $display("FAIL pass_data: got %h/%h expected 00001234/ffff0000",
                               left_channel_audio_out, right_channel_audio_out);
        end
    endtask

    task automatic test_mix_saturation();
        run_slot(3, 32'h7FFFFF00, 32'h00000010, 1'b1, 32'h00001000, 32'h00000020, 1);
        n_checks++;
        if (left_channel_audio_out !== 32'h7FFFFFFF || right_channel_audio_out !== 32'h00000030) begin
            n_fail++; $display("FAIL mix_sat_pos: got %h/%h expected 7fffffff/00000030",
                               left_channel_audio_out, right_channel_audio_out);
        end
        run_slot(3, 32'h80000010, 32'hFFFFFFF0, 1'b1, 32'hFFFFFF00, 32'h00000005, 0);
        n_checks++;
        if (left_channel_audio_out !== 32'h80000000 || right_channel_audio_out !== 32'hFFFFFFF5) begin
            n_fail++; $display("FAIL mix_sat_neg: got %h/%h expected 80000000/fffffff5",
                               left_channel_audio_out, right_channel_audio_out);
        end
    endtask

    task automatic test_tone_underrun();
        test_reset();
        for (int i = 0; i < 3; i++) begin
            run_slot(2, $urandom, $urandom, 1'b0, $urandom, $urandom, 0);
        end
        n_checks++;
        if (underrun_cnt !== CNT_W'(3) || left_channel_audio_out !== 32'd0) begin
            n_fail++; $display("FAIL tone_underrun: got und=%0d out=%h expected 3 00000000",
                               underrun_cnt, left_channel_audio_out);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        run_slot(1, 32'h0000_0ABC, 32'h0000_0DEF, 1'b0, '0, '0, OUT_TIMEOUT);
        n_checks++;
        if (drop_cnt !== CNT_W'(1)) begin
            n_fail++; $display("FAIL timeout_drop: got %0d expected 1", drop_cnt);
        end
        run_slot(1, 32'h0000_0123, 32'h0000_0456, 1'b0, '0, '0, OUT_TIMEOUT - 1);
        n_checks++;
        if (drop_cnt !== CNT_W'(1) || left_channel_audio_out !== 32'h0000_0123) begin
            n_fail++; $display("FAIL timeout_recover: got drop=%0d out=%h expected 1 00000123",
                               drop_cnt, left_channel_audio_out);
        end
    endtask

    task automatic test_frame();
        test_reset();
        for (int i = 0; i < 9; i++) begin
            run_slot(1, rand_sample(), rand_sample(), 1'b0, '0, '0, 0);
        end
        n_checks++;
        if (tick_count !== 2) begin
            n_fail++; $display("FAIL frame_tick_count: got %0d expected 2", tick_count);
        end
    endtask

    task automatic test_saturation();
        test_reset();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            run_slot(3, rand_sample(), rand_sample(), 1'b0, '0, '0, 0);
        end
        n_checks++;
        if (underrun_cnt !== CNT_W'(CNT_MAX)) begin
            n_fail++; $display("FAIL underrun_saturate: got %0d expected %0d", underrun_cnt, CNT_MAX);
        end
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            run_slot(0, rand_sample(), rand_sample(), 1'b1, '0, '0, OUT_TIMEOUT + 3);
        end
        n_checks++;
        if (drop_cnt !== CNT_W'(CNT_MAX)) begin
            n_fail++; $display("FAIL drop_saturate: got %0d expected %0d", drop_cnt, CNT_MAX);
        end
    endtask

    task automatic test_random();
        int stall;
        test_reset();
        for (int i = 0; i < 250; i++) begin
            stall = ($urandom_range(0, 19) == 0) ? OUT_TIMEOUT : $urandom_range(0, 3);
            run_slot($urandom_range(0, 3), rand_sample(), rand_sample(), 1'($urandom_range(0, 1)),
                     rand_sample(), rand_sample(), stall);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_slot();
        test_pass();
        test_mix_saturation();
        test_tone_underrun();
        test_timeout();
        test_frame();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
